// File: rtl/eth_idma_pkg.sv
// eth_idma_pkg: shared iDMA/Ethernet types, protocol enum and padded-union width helpers
package eth_idma_pkg;

    localparam int unsigned PkgDataWidth  = 64;
    localparam int unsigned PkgStrbWidth  = PkgDataWidth / 8;
    localparam int unsigned PkgAddrWidth  = 32;
    localparam int unsigned PkgAxiIdWidth = 5;
    localparam int unsigned PkgTFLenWidth = 32;
    localparam int unsigned PkgUserWidth  = 1;

    typedef enum logic {
        META_AXI  = 1'b0,
        META_AXIS = 1'b1
    } meta_proto_e;

    function automatic int unsigned max_width(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // Width of a packed union whose members are each padded up to the widest one
    function automatic int unsigned padded_union_width(input int unsigned a, input int unsigned b);
        return max_width(a, b);
    endfunction

    typedef struct packed {
        logic [PkgAxiIdWidth-1:0] axi_id;
    } idma_opt_t;

    typedef struct packed {
        logic [PkgTFLenWidth-1:0] length;
        logic [PkgAddrWidth-1:0]  src_addr;
        idma_opt_t                opt;
    } idma_req_t;

    typedef struct packed {
        logic [PkgAxiIdWidth-1:0] id;
        logic [PkgAddrWidth-1:0]  addr;
        logic [7:0]               len;
        logic [2:0]               size;
        logic [1:0]               burst;
        logic                     lock;
        logic [3:0]               cache;
        logic [2:0]               prot;
        logic [3:0]               qos;
        logic [3:0]               region;
        logic [PkgUserWidth-1:0]  user;
    } axi_ar_chan_t;

    typedef struct packed {
        logic [PkgDataWidth-1:0]  tdata;
        logic [PkgStrbWidth-1:0]  tstrb;
        logic [PkgStrbWidth-1:0]  tkeep;
        logic                     tlast;
        logic [PkgAxiIdWidth-1:0] tid;
        logic [PkgAxiIdWidth-1:0] tdest;
        logic [PkgUserWidth-1:0]  tuser;
    } axis_t_chan_t;

    localparam int unsigned ReadMetaWidth = padded_union_width($bits(axi_ar_chan_t), $bits(axis_t_chan_t));

    // The AR beat is the narrower member, so it carries the padding
    typedef struct packed {
        logic [ReadMetaWidth-$bits(axi_ar_chan_t)-1:0] pad;
        axi_ar_chan_t                                  ar;
    } axi_ar_padded_t;

    typedef union packed {
        axi_ar_padded_t axi;
        axis_t_chan_t   axis;
    } read_meta_channel_t;

endpackage

// File: rtl/eth_idma_meta_fifo.sv
// eth_idma_meta_fifo: synchronous Depth-entry FIFO with full/empty flags and occupancy count
module eth_idma_meta_fifo #(
    parameter int unsigned  Depth  = 4,
    parameter type          elem_t = logic,
    localparam int unsigned PtrW   = $clog2(Depth),
    localparam int unsigned CntW   = PtrW + 1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            i_push,
    input  elem_t           i_data,
    input  logic            i_pop,
    output elem_t           o_data,
    output logic            o_full,
    output logic            o_empty,
    output logic [CntW-1:0] o_fill
);

    elem_t           r_mem [Depth];
    logic [PtrW-1:0] r_wr;
    logic [PtrW-1:0] r_rd;
    logic [CntW-1:0] r_fill;
    logic            w_push;
    logic            w_pop;

    assign o_full  = (r_fill == CntW'(Depth));
    assign o_empty = (r_fill == '0);
    assign o_fill  = r_fill;
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;
    // An empty FIFO presents an all-zero word so the head never shows stale storage
    assign o_data  = o_empty ? '0 : r_mem[r_rd];

    // Pointers wrap naturally because Depth is a power of two
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_wr   <= '0;
            r_rd   <= '0;
            r_fill <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop) r_rd <= r_rd + 1'b1;
            r_fill <= r_fill + CntW'(w_push) - CntW'(w_pop);
        end
    end

    // Storage needs no reset; occupancy decides what is visible
    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wr] <= i_data;
    end

endmodule

// File: rtl/eth_idma_meta_arbiter.sv
// eth_idma_meta_arbiter: round-robin iDMA request arbiter converting requests into AXI AR / AXIS T meta words ahead of a FIFO.
// Define ETH_IDMA_META_STATS_EN to add per-channel accept counters on acc_cnt_o.
module eth_idma_meta_arbiter
    import eth_idma_pkg::*;
#(
    parameter int unsigned  NumChannels = 2,
    parameter int unsigned  Depth       = 4,
    parameter int unsigned  DataWidth   = 64,
    parameter int unsigned  AddrWidth   = 32,
    parameter int unsigned  AxiIdWidth  = 5,
    parameter int unsigned  TFLenWidth  = 32,
    parameter type          req_t       = idma_req_t,
    parameter type          meta_t      = read_meta_channel_t,
    localparam int unsigned StrbWidth   = DataWidth / 8,
    localparam int unsigned OffsetWidth = $clog2(StrbWidth),
    localparam int unsigned ChanW       = (NumChannels > 1) ? $clog2(NumChannels) : 1,
    localparam int unsigned FillW       = $clog2(Depth) + 1
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  req_t [NumChannels-1:0]       req_i,
    input  logic [NumChannels-1:0]       req_valid_i,
    output logic [NumChannels-1:0]       req_ready_o,
    input  logic [NumChannels-1:0]       proto_i,
    output meta_t                        meta_o,
    output logic                         meta_proto_o,
    output logic [ChanW-1:0]             meta_chan_o,
    output logic                         meta_valid_o,
    input  logic                         meta_ready_i,
    output logic                         drop_o,
`ifdef ETH_IDMA_META_STATS_EN
    output logic [NumChannels-1:0][15:0] acc_cnt_o,
`endif
    output logic [FillW-1:0]             fill_o
);

    localparam int unsigned LenW = TFLenWidth + 1;

    typedef struct packed {
        meta_proto_e      proto;
        logic [ChanW-1:0] chan;
        meta_t            meta;
    } elem_t;

    logic [ChanW-1:0]       r_rr;
    logic [ChanW-1:0]       w_sel;
    logic [ChanW-1:0]       w_idx;
    logic [NumChannels-1:0] w_grant;
    logic                   w_any;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_zero;
    logic                   w_accept;
    logic                   w_push;
    logic [LenW-1:0]        w_sum;
    logic [LenW-1:0]        w_beats;
    req_t                   w_req;
    meta_proto_e            w_proto;
    meta_t                  w_meta;
    elem_t                  w_push_elem;
    elem_t                  w_head;

    // Round-robin search for the first valid channel starting at r_rr
    always_comb begin
        w_grant = '0;
        w_sel   = '0;
        w_idx   = '0;
        w_any   = 1'b0;
        for (int i = 0; i < NumChannels; i++) begin
            w_idx = ChanW'((32'(r_rr) + 32'(i)) % NumChannels);
            if (!w_any && req_valid_i[w_idx]) begin
                w_any = 1'b1;
                w_sel = w_idx;
            end
        end
        w_grant[w_sel] = w_any;
    end

    assign w_req       = req_i[w_sel];
    assign w_proto     = meta_proto_e'(proto_i[w_sel]);
    assign w_zero      = (w_req.length == '0);
    // Fullness is judged before any same-cycle pop; zero-length requests bypass the FIFO
    assign req_ready_o = w_grant & {NumChannels{rst_ni & (~w_full | w_zero)}};
    assign w_accept    = |req_ready_o;
    assign w_push      = w_accept & ~w_zero;
    assign drop_o      = w_accept & w_zero;
    assign w_sum       = {1'b0, w_req.length} + LenW'(w_req.src_addr[OffsetWidth-1:0]) - LenW'(1);
    assign w_beats     = w_sum >> OffsetWidth;

    // Convert the granted request into an AR beat or an AXIS T beat
    always_comb begin
        w_meta = '0;
        if (w_proto == META_AXIS) begin
            w_meta.axis.tid   = AxiIdWidth'(w_sel);
            w_meta.axis.tdest = w_req.opt.axi_id;
            w_meta.axis.tkeep = '1;
            w_meta.axis.tstrb = '1;
            w_meta.axis.tlast = 1'b1;
        end else begin
            w_meta.axi.ar.addr  = AddrWidth'(w_req.src_addr);
            w_meta.axi.ar.id    = AxiIdWidth'(w_sel);
            w_meta.axi.ar.size  = 3'(OffsetWidth);
            w_meta.axi.ar.burst = 2'b01;
            w_meta.axi.ar.len   = (w_beats > LenW'(255)) ? 8'hFF : w_beats[7:0];
        end
    end

    assign w_push_elem = '{proto: w_proto, chan: w_sel, meta: w_meta};

    // Advance the round-robin pointer past the channel just accepted
    always_ff @(posedge clk_i) begin
        if (!rst_ni) r_rr <= '0;
        else if (w_accept) r_rr <= (32'(w_sel) == NumChannels - 1) ? '0 : w_sel + 1'b1;
    end

    eth_idma_meta_fifo #(
        .Depth  (Depth),
        .elem_t (elem_t)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .i_push  (w_push),
        .i_data  (w_push_elem),
        .i_pop   (meta_ready_i),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_fill  (fill_o)
    );

    assign meta_valid_o = ~w_empty;
    assign meta_o       = w_head.meta;
    assign meta_proto_o = w_head.proto;
    assign meta_chan_o  = w_head.chan;

`ifdef ETH_IDMA_META_STATS_EN
    logic [NumChannels-1:0][15:0] r_acc_cnt;

    // Count every accept per channel, zero-length ones included; wraps at 2^16
    always_ff @(posedge clk_i) begin
        if (!rst_ni) r_acc_cnt <= '0;
        else for (int k = 0; k < NumChannels; k++) if (req_ready_o[k]) r_acc_cnt[k] <= r_acc_cnt[k] + 16'd1;
    end

    assign acc_cnt_o = r_acc_cnt;
`endif

endmodule
